// File: rtl/rc_bank_pipe.sv
// Single-bank cache data pipe: one execute stage over a SETS x WAYS line array,
// write-buffer merge, response FIFO and write-back port. Optional macro RC_RSP_BYPASS_EN.
module rc_bank_pipe #(
  parameter int CL_WIDTH   = 256,
  parameter int WORD_WIDTH = 128,
  parameter int SETS       = 8,
  parameter int WAYS       = 4,
  parameter int N_CH       = 4,
  parameter int ROB_W      = 4,
  parameter int WBUF_W     = 7,
  parameter int NLINE_W    = 32,
  parameter int RSP_DEPTH  = 4,
  localparam int WPL = CL_WIDTH / WORD_WIDTH,
  localparam int SW  = $clog2(SETS),
  localparam int WW  = $clog2(WAYS),
  localparam int OW  = $clog2(WPL),
  localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  isu_valid,
  output logic                  isu_ready,
  input  logic [N_CH-1:0]       isu_channel_1hot_id,
  input  logic [ROB_W-1:0]      isu_rob_id,
  input  logic [2:0]            isu_op,
  input  logic [SW-1:0]         isu_set,
  input  logic [WW-1:0]         isu_way,
  input  logic [OW-1:0]         isu_offset,
  input  logic [WBUF_W-1:0]     isu_wbuf_id,
  input  logic [NLINE_W-1:0]    isu_nline,
  input  logic [CL_WIDTH-1:0]   isu_refill_data,
  output logic                  wbuf_req_valid,
  output logic [WBUF_W-1:0]     wbuf_req_id,
  input  logic [WORD_WIDTH-1:0] wbuf_rsp_data,
  output logic                  bank_rsp_valid,
  input  logic                  bank_rsp_ready,
  output logic [ROB_W-1:0]      bank_rsp_rob_id,
  output logic [CW-1:0]         bank_rsp_channel_id,
  output logic [WORD_WIDTH-1:0] bank_rsp_data,
  output logic                  memctl_wvalid,
  input  logic                  memctl_wready,
  output logic [NLINE_W-1:0]    memctl_wid,
  output logic [CL_WIDTH-1:0]   memctl_wdata
);

  localparam int LINES = SETS * WAYS;
  localparam int LW    = SW + WW;
  localparam int PW    = $clog2(RSP_DEPTH);
  localparam int CNTW  = PW + 1;

  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_LREF = 3'd3;
  localparam logic [2:0] OP_SREF = 3'd4;
  localparam logic [2:0] OP_WB = 3'd5;

  logic                  accept;
  logic [CW-1:0]         isu_ch_idx;

  logic                  ex_valid;
  logic [2:0]            ex_op;
  logic [ROB_W-1:0]      ex_rob;
  logic [CW-1:0]         ex_ch;
  logic [SW-1:0]         ex_set;
  logic [WW-1:0]         ex_way;
  logic [OW-1:0]         ex_off;
  logic [NLINE_W-1:0]    ex_nline;
  logic [CL_WIDTH-1:0]   ex_refill;

  logic                  ex_is_load;
  logic                  ex_is_wb;
  logic [LW-1:0]         line_idx;
  logic [CL_WIDTH-1:0]   cur_line;
  logic [WORD_WIDTH-1:0] ld_word;
  logic                  wr_en;
  logic [CL_WIDTH-1:0]   wr_line;

  logic [CL_WIDTH-1:0]   mem [LINES];

  logic [ROB_W-1:0]      fifo_rob  [RSP_DEPTH];
  logic [CW-1:0]         fifo_ch   [RSP_DEPTH];
  logic [WORD_WIDTH-1:0] fifo_data [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CNTW-1:0]       rsp_count;
  logic [CNTW-1:0]       occupancy;
  logic                  fifo_nempty;
  logic                  bypass;
  logic                  push;
  logic                  pop;

  // Ready counts the load sitting in execute so a full FIFO can never be overrun.
  assign occupancy = rsp_count + CNTW'(ex_is_load);
  assign isu_ready = (occupancy < CNTW'(RSP_DEPTH)) && !memctl_wvalid && !ex_is_wb;
  assign accept    = isu_valid && isu_ready;

  assign wbuf_req_valid = accept && (isu_op == OP_STORE || isu_op == OP_SREF);
  assign wbuf_req_id    = wbuf_req_valid ? isu_wbuf_id : '0;

  always_comb begin
    isu_ch_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (isu_channel_1hot_id[i]) isu_ch_idx = CW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_op     <= '0;
      ex_rob    <= '0;
      ex_ch     <= '0;
      ex_set    <= '0;
      ex_way    <= '0;
      ex_off    <= '0;
      ex_nline  <= '0;
      ex_refill <= '0;
    end else begin
      ex_valid <= accept;
      if (accept) begin
        ex_op     <= isu_op;
        ex_rob    <= isu_rob_id;
        ex_ch     <= isu_ch_idx;
        ex_set    <= isu_set;
        ex_way    <= isu_way;
        ex_off    <= isu_offset;
        ex_nline  <= isu_nline;
        ex_refill <= isu_refill_data;
      end
    end
  end

  assign ex_is_load = ex_valid && (ex_op == OP_LOAD || ex_op == OP_LREF);
  assign ex_is_wb   = ex_valid && (ex_op == OP_WB);
  assign line_idx   = {ex_set, ex_way};
  assign cur_line   = mem[line_idx];
  assign ld_word    = (ex_op == OP_LREF) ? ex_refill[int'(ex_off)*WORD_WIDTH +: WORD_WIDTH]
                                         : cur_line[int'(ex_off)*WORD_WIDTH +: WORD_WIDTH];

  always_comb begin
    wr_en   = 1'b0;
    wr_line = cur_line;
    if (ex_valid) begin
      case (ex_op)
        OP_STORE: begin
          wr_en = 1'b1;
          wr_line[int'(ex_off)*WORD_WIDTH +: WORD_WIDTH] = wbuf_rsp_data;
        end
        OP_LREF: begin
          wr_en   = 1'b1;
          wr_line = ex_refill;
        end
        OP_SREF: begin
          wr_en   = 1'b1;
          wr_line = ex_refill;
          wr_line[int'(ex_off)*WORD_WIDTH +: WORD_WIDTH] = wbuf_rsp_data;
        end
        default: wr_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[line_idx] <= wr_line;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memctl_wvalid <= 1'b0;
      memctl_wid    <= '0;
      memctl_wdata  <= '0;
    end else if (ex_is_wb) begin
      memctl_wvalid <= 1'b1;
      memctl_wid    <= ex_nline;
      memctl_wdata  <= cur_line;
    end else if (memctl_wvalid && memctl_wready) begin
      memctl_wvalid <= 1'b0;
    end
  end

  assign fifo_nempty = (rsp_count != '0);

`ifdef RC_RSP_BYPASS_EN
  assign bypass = ex_is_load && !fifo_nempty && bank_rsp_ready;
`else
  assign bypass = 1'b0;
`endif

  assign push = ex_is_load && !bypass;
  assign pop  = fifo_nempty && bank_rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rsp_count <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_rob[i]  <= '0;
        fifo_ch[i]   <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_rob[wr_ptr]  <= ex_rob;
        fifo_ch[wr_ptr]   <= ex_ch;
        fifo_data[wr_ptr] <= ld_word;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   rsp_count <= rsp_count + 1'b1;
        2'b01:   rsp_count <= rsp_count - 1'b1;
        default: rsp_count <= rsp_count;
      endcase
    end
  end

  always_comb begin
    bank_rsp_valid      = 1'b0;
    bank_rsp_rob_id     = '0;
    bank_rsp_channel_id = '0;
    bank_rsp_data       = '0;
    if (fifo_nempty) begin
      bank_rsp_valid      = 1'b1;
      bank_rsp_rob_id     = fifo_rob[rd_ptr];
      bank_rsp_channel_id = fifo_ch[rd_ptr];
      bank_rsp_data       = fifo_data[rd_ptr];
    end else if (bypass) begin
      bank_rsp_valid      = 1'b1;
      bank_rsp_rob_id     = ex_rob;
      bank_rsp_channel_id = ex_ch;
      bank_rsp_data       = ld_word;
    end
  end

endmodule

// File: tb/tb_rc_bank_pipe.sv
// Scoreboard bench for rc_bank_pipe (default build): directed ops, monitor checks responses.
module tb_rc_bank_pipe;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          isu_valid = 1'b0;
  logic          isu_ready;
  logic [3:0]    isu_channel_1hot_id = '0;
  logic [3:0]    isu_rob_id = '0;
  logic [2:0]    isu_op = '0;
  logic [2:0]    isu_set = '0;
  logic [1:0]    isu_way = '0;
  logic [0:0]    isu_offset = '0;
  logic [6:0]    isu_wbuf_id = '0;
  logic [31:0]   isu_nline = '0;
  logic [255:0]  isu_refill_data = '0;
  logic          wbuf_req_valid;
  logic [6:0]    wbuf_req_id;
  logic [127:0]  wbuf_rsp_data = '0;
  logic          bank_rsp_valid;
  logic          bank_rsp_ready = 1'b1;
  logic [3:0]    bank_rsp_rob_id;
  logic [1:0]    bank_rsp_channel_id;
  logic [127:0]  bank_rsp_data;
  logic          memctl_wvalid;
  logic          memctl_wready = 1'b0;
  logic [31:0]   memctl_wid;
  logic [255:0]  memctl_wdata;

  typedef struct packed {
    logic [3:0]   rob;
    logic [1:0]   ch;
    logic [127:0] data;
  } rsp_t;

  rsp_t         exp_q[$];
  logic [127:0] wbuf_tab [128];
  int           vectors = 0;
  int           miscompares = 0;

  localparam logic [127:0] W_A    = 128'haaaa_bbbb_cccc_dddd;
  localparam logic [127:0] W_A1   = 128'h1111_2222_3333_4444;
  localparam logic [127:0] W_D    = 128'hdddd_cccc_bbbb_aaaa;
  localparam logic [127:0] W_6    = 128'h6666;
  localparam logic [127:0] W_5    = 128'h5555;
  localparam logic [127:0] W_ST   = 128'h1234_5678;

  rc_bank_pipe dut (
    .clk(clk), .rst(rst),
    .isu_valid(isu_valid), .isu_ready(isu_ready),
    .isu_channel_1hot_id(isu_channel_1hot_id), .isu_rob_id(isu_rob_id),
    .isu_op(isu_op), .isu_set(isu_set), .isu_way(isu_way), .isu_offset(isu_offset),
    .isu_wbuf_id(isu_wbuf_id), .isu_nline(isu_nline), .isu_refill_data(isu_refill_data),
    .wbuf_req_valid(wbuf_req_valid), .wbuf_req_id(wbuf_req_id), .wbuf_rsp_data(wbuf_rsp_data),
    .bank_rsp_valid(bank_rsp_valid), .bank_rsp_ready(bank_rsp_ready),
    .bank_rsp_rob_id(bank_rsp_rob_id), .bank_rsp_channel_id(bank_rsp_channel_id),
    .bank_rsp_data(bank_rsp_data),
    .memctl_wvalid(memctl_wvalid), .memctl_wready(memctl_wready),
    .memctl_wid(memctl_wid), .memctl_wdata(memctl_wdata)
  );

  always #5 clk = ~clk;

  // Write-buffer responder: fixed one-cycle read latency.
  always @(posedge clk) wbuf_rsp_data <= wbuf_req_valid ? wbuf_tab[wbuf_req_id] : '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: every handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bank_rsp_valid && bank_rsp_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_unexpected: got rob %0d ch %0d data %h expected no response",
                 bank_rsp_rob_id, bank_rsp_channel_id, bank_rsp_data);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        if (bank_rsp_rob_id !== e.rob || bank_rsp_channel_id !== e.ch || bank_rsp_data !== e.data) begin
          miscompares++;
          $display("FAIL rsp_data: got rob %0d ch %0d data %h expected rob %0d ch %0d data %h",
                   bank_rsp_rob_id, bank_rsp_channel_id, bank_rsp_data, e.rob, e.ch, e.data);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [2:0] set, input logic [1:0] way,
                       input logic off, input logic [3:0] rob, input logic [3:0] ch1h,
                       input logic [6:0] wid, input logic [31:0] nline, input logic [255:0] refill,
                       input logic [127:0] exp_d, input logic [1:0] exp_ch);
    int k;
    isu_op = op; isu_set = set; isu_way = way; isu_offset = off; isu_rob_id = rob;
    isu_channel_1hot_id = ch1h; isu_wbuf_id = wid; isu_nline = nline; isu_refill_data = refill;
    isu_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!isu_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!isu_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL issue_timeout: got isu_ready 0 expected 1 within 50 cycles");
    end else begin
      if (op == 3'd1 || op == 3'd3) exp_q.push_back('{rob: rob, ch: exp_ch, data: exp_d});
      if (op == 3'd2 || op == 3'd4) begin
        check("wbuf_req_valid", 256'(wbuf_req_valid), 256'(1));
        check("wbuf_req_id", 256'(wbuf_req_id), 256'(wid));
      end
    end
    @(posedge clk);
    #1;
    isu_valid = 1'b0;
  endtask

  initial begin
    int k;
    for (int i = 0; i < 128; i++) wbuf_tab[i] = '0;
    wbuf_tab[5] = W_D;
    wbuf_tab[2] = W_ST;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_isu_ready", 256'(isu_ready), 256'(1));
    check("rst_rsp_valid", 256'(bank_rsp_valid), 256'(0));
    check("rst_memctl_wvalid", 256'(memctl_wvalid), 256'(0));
    check("rst_wbuf_req_valid", 256'(wbuf_req_valid), 256'(0));
    check("rst_rsp_data", 256'(bank_rsp_data), 256'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // LOAD_REFILL: response first appears at T+2
    issue(3'd3, 3'd1, 2'd1, 1'b0, 4'd7, 4'b0001, 7'd0, 32'd0, {W_A1, W_A}, W_A, 2'd0);
    @(negedge clk);
    check("lref_lat_t1", 256'(bank_rsp_valid), 256'(0));
    @(negedge clk);
    check("lref_lat_t2", 256'(bank_rsp_valid), 256'(1));
    @(posedge clk);
    #1;

    // STORE_REFILL then back-to-back loads of the merged line
    issue(3'd4, 3'd1, 2'd2, 1'b1, 4'd0, 4'b0001, 7'd5, 32'd0, {W_5, W_6}, '0, 2'd0);
    issue(3'd1, 3'd1, 2'd2, 1'b1, 4'd3, 4'b0100, 7'd0, 32'd0, '0, W_D, 2'd2);
    issue(3'd1, 3'd1, 2'd2, 1'b0, 4'd4, 4'b1000, 7'd0, 32'd0, '0, W_6, 2'd3);

    // STORE into an existing line, then read both words; odd channel encodings
    issue(3'd2, 3'd1, 2'd1, 1'b1, 4'd0, 4'b0001, 7'd2, 32'd0, '0, '0, 2'd0);
    issue(3'd1, 3'd1, 2'd1, 1'b1, 4'd5, 4'b0110, 7'd0, 32'd0, '0, W_ST, 2'd1);
    issue(3'd1, 3'd1, 2'd1, 1'b0, 4'd6, 4'b0000, 7'd0, 32'd0, '0, W_A, 2'd0);
    issue(3'd7, 3'd1, 2'd1, 1'b0, 4'd9, 4'b0001, 7'd0, 32'd0, '0, '0, 2'd0);
    repeat (3) @(posedge clk);
    #1;

    // Write-back held against a stalled memory controller
    issue(3'd5, 3'd1, 2'd2, 1'b0, 4'd0, 4'b0001, 7'd0, 32'h40, '0, '0, 2'd0);
    @(negedge clk);
    check("wb_t1_ready", 256'(isu_ready), 256'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("wb_wvalid", 256'(memctl_wvalid), 256'(1));
      check("wb_wid", 256'(memctl_wid), 256'(32'h40));
      check("wb_wdata", memctl_wdata, {W_D, W_6});
      check("wb_isu_ready", 256'(isu_ready), 256'(0));
    end
    @(posedge clk);
    #1 memctl_wready = 1'b1;
    @(posedge clk);
    #1 memctl_wready = 1'b0;
    @(negedge clk);
    check("wb_done_wvalid", 256'(memctl_wvalid), 256'(0));
    check("wb_done_ready", 256'(isu_ready), 256'(1));
    @(posedge clk);
    #1;

    // Four loads against a stalled consumer fill the FIFO
    bank_rsp_ready = 1'b0;
    issue(3'd1, 3'd1, 2'd1, 1'b0, 4'd8, 4'b0001, 7'd0, 32'd0, '0, W_A, 2'd0);
    issue(3'd1, 3'd1, 2'd1, 1'b1, 4'd9, 4'b0010, 7'd0, 32'd0, '0, W_ST, 2'd1);
    issue(3'd1, 3'd1, 2'd2, 1'b1, 4'd10, 4'b0100, 7'd0, 32'd0, '0, W_D, 2'd2);
    issue(3'd1, 3'd1, 2'd2, 1'b0, 4'd11, 4'b1000, 7'd0, 32'd0, '0, W_6, 2'd3);
    @(negedge clk);
    check("full_isu_ready", 256'(isu_ready), 256'(0));
    check("full_rsp_valid", 256'(bank_rsp_valid), 256'(1));
    @(negedge clk);
    check("stall_hold_data", 256'(bank_rsp_data), 256'(W_A));
    check("stall_hold_rob", 256'(bank_rsp_rob_id), 256'(8));
    @(posedge clk);
    #1 bank_rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("drain_q_empty", 256'(exp_q.size()), 256'(0));

    // Reset with responses pending
    bank_rsp_ready = 1'b0;
    issue(3'd1, 3'd1, 2'd1, 1'b0, 4'd1, 4'b0001, 7'd0, 32'd0, '0, W_A, 2'd0);
    issue(3'd1, 3'd1, 2'd2, 1'b0, 4'd2, 4'b0001, 7'd0, 32'd0, '0, W_6, 2'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pre_rst_valid", 256'(bank_rsp_valid), 256'(1));
    rst = 1'b1;
    #1;
    check("async_rst_valid", 256'(bank_rsp_valid), 256'(0));
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    bank_rsp_ready = 1'b1;
    issue(3'd1, 3'd1, 2'd1, 1'b0, 4'd12, 4'b0010, 7'd0, 32'd0, '0, '0, 2'd1);

    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("final_q_empty", 256'(exp_q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
